// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree ensemble walker: FSM states,
// node-word layout and the node-word packing helper.
package dtree_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Wide enough for any node word the parameter ranges can produce.
  localparam int PACK_W = 64;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Field widths as functions of the ensemble parameters.
  function automatic int feat_w(input int n_feat);
    return clog2_min1(n_feat);
  endfunction

  function automatic int addr_w(input int n_nodes);
    return clog2_min1(n_nodes);
  endfunction

  // Node word layout, LSB first: f_ptr | t_ptr | feat_idx | leaf.
  function automatic int f_ptr_lsb();
    return 0;
  endfunction

  function automatic int t_ptr_lsb(input int aw);
    return aw;
  endfunction

  function automatic int feat_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int leaf_bit(input int fw, input int aw);
    return fw + 2 * aw;
  endfunction

  function automatic int node_w(input int fw, input int aw);
    return 1 + fw + 2 * aw;
  endfunction

  function automatic logic [PACK_W-1:0] field_mask(input int w);
    return (PACK_W'(1) << w) - PACK_W'(1);
  endfunction

  // Builds a node word; callers truncate to node_w(fw, aw) bits.
  function automatic logic [PACK_W-1:0] pack_node(input logic        leaf,
                                                  input int unsigned feat_idx,
                                                  input int unsigned t_ptr,
                                                  input int unsigned f_ptr,
                                                  input int          fw,
                                                  input int          aw);
    logic [PACK_W-1:0] w;
    w = (PACK_W'(f_ptr) & field_mask(aw)) << f_ptr_lsb();
    w |= (PACK_W'(t_ptr) & field_mask(aw)) << t_ptr_lsb(aw);
    w |= (PACK_W'(feat_idx) & field_mask(fw)) << feat_lsb(aw);
    w |= PACK_W'(leaf) << leaf_bit(fw, aw);
    return w;
  endfunction

endpackage

// File: rtl/dtree_walker_if.sv
// Configuration, feature and result ports of the tree walker.
interface dtree_walker_if
  import dtree_pkg::*;
#(
  parameter int N_FEAT  = 51,
  parameter int N_NODES = 64,
  parameter int N_TREES = 4,
  parameter int N_CLASS = 2
);
  localparam int FW = feat_w(N_FEAT);
  localparam int AW = addr_w(N_NODES);
  localparam int TW = clog2_min1(N_TREES);
  localparam int CW = clog2_min1(N_CLASS);
  localparam int NW = node_w(FW, AW);

  logic              cfg_ready;
  logic              cfg_node_we;
  logic [AW-1:0]     cfg_node_addr;
  logic [NW-1:0]     cfg_node_wdata;
  logic              cfg_root_we;
  logic [TW-1:0]     cfg_root_idx;
  logic [AW-1:0]     cfg_root_addr;
  logic              in_valid;
  logic              in_ready;
  logic [N_FEAT-1:0] in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_class;
  logic              out_err;

  modport master (
    output cfg_node_we, cfg_node_addr, cfg_node_wdata,
    output cfg_root_we, cfg_root_idx, cfg_root_addr,
    output in_valid, in_feat, out_ready,
    input  cfg_ready, in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  cfg_node_we, cfg_node_addr, cfg_node_wdata,
    input  cfg_root_we, cfg_root_idx, cfg_root_addr,
    input  in_valid, in_feat, out_ready,
    output cfg_ready, in_ready, out_valid, out_class, out_err
  );

endinterface

// File: rtl/dtree_vote_acc.sv
// Per-class vote counters with clear/increment and lowest-index argmax.
module dtree_vote_acc
  import dtree_pkg::*;
#(
  parameter int N_CLASS = 2,
  parameter int N_TREES = 4,
  localparam int CW = clog2_min1(N_CLASS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] inc_class,
  output logic [CW-1:0] win_class
);

  // One vote per tree at most, so N_TREES+1 values never overflow.
  localparam int VW = clog2_min1(N_TREES + 1);

  logic [VW-1:0] cnt_q [N_CLASS];
  logic [VW-1:0] best_cnt;

  // Counter update: clear wins over increment; out-of-range classes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CLASS; c++) cnt_q[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < N_CLASS; c++) cnt_q[c] <= '0;
    end else if (inc) begin
      for (int c = 0; c < N_CLASS; c++)
        if (inc_class == CW'(c)) cnt_q[c] <= cnt_q[c] + 1'b1;
    end
  end

  // Argmax over the registered counts; strict '>' keeps ties on the lower index.
  always_comb begin
    // NOTE: blocking assignments here model a running maximum within one evaluation.
    best_cnt  = cnt_q[0];
    win_class = '0;
    for (int c = 1; c < N_CLASS; c++) begin
      if (cnt_q[c] > best_cnt) begin
        best_cnt  = cnt_q[c];
        win_class = CW'(c);
      end
    end
  end

endmodule

// File: rtl/dtree_walker.sv
// Table-driven decision-tree ensemble evaluator: one node per clock,
// one vote per tree, majority class returned over valid/ready.
module dtree_walker
  import dtree_pkg::*;
#(
  parameter int N_FEAT    = 51,
  parameter int N_NODES   = 64,
  parameter int N_TREES   = 4,
  parameter int N_CLASS   = 2,
  parameter int MAX_DEPTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  dtree_walker_if.slave bus
);

  localparam int FW       = feat_w(N_FEAT);
  localparam int AW       = addr_w(N_NODES);
  localparam int TW       = clog2_min1(N_TREES);
  localparam int CW       = clog2_min1(N_CLASS);
  localparam int DW       = clog2_min1(MAX_DEPTH);
  localparam int NW       = node_w(FW, AW);
  localparam int F_LSB    = f_ptr_lsb();
  localparam int T_LSB    = t_ptr_lsb(AW);
  localparam int X_LSB    = feat_lsb(AW);
  localparam int L_BIT    = leaf_bit(FW, AW);
  localparam int FEAT_EXT = 1 << FW;
  localparam logic [NW-1:0] NODE_RST = NW'(pack_node(1'b1, 0, 0, 0, FW, AW));

  state_t            state_q, state_d;
  logic [NW-1:0]     node_mem [N_NODES];
  logic [AW-1:0]     root_mem [N_TREES];
  logic [N_FEAT-1:0] feat_q;
  logic [TW-1:0]     tree_q, tree_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_q, err_d;
  logic              feat_ld, vote_clr, vote_inc, advance;
  logic              in_ready_c, out_valid_c, cfg_ready_c;
  logic [CW-1:0]     win_class;

  // Current node decode; feature indices beyond N_FEAT read as 0.
  logic [NW-1:0]       node_rd;
  logic                node_leaf, bad_feat, class_ok, feat_bit, last_tree;
  logic [FW-1:0]       node_feat;
  logic [AW-1:0]       node_t, node_f;
  logic [CW-1:0]       node_cls;
  logic [FEAT_EXT-1:0] feat_ext;

  assign node_rd   = node_mem[ptr_q];
  assign node_leaf = node_rd[L_BIT];
  assign node_feat = node_rd[X_LSB +: FW];
  assign node_t    = node_rd[T_LSB +: AW];
  assign node_f    = node_rd[F_LSB +: AW];
  assign node_cls  = node_f[CW-1:0];
  assign feat_ext  = FEAT_EXT'(feat_q);
  assign bad_feat  = int'(node_feat) >= N_FEAT;
  assign feat_bit  = !bad_feat && feat_ext[node_feat];
  assign class_ok  = int'(node_cls) < N_CLASS;
  assign last_tree = (tree_q == TW'(N_TREES - 1));

  assign cfg_ready_c = (state_q == IDLE);

  // Node table and root pointers; writes land only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is reset on purpose (leaf class 0, roots 0), which rules out a RAM macro.
      for (int i = 0; i < N_NODES; i++) node_mem[i] <= NODE_RST;
      for (int i = 0; i < N_TREES; i++) root_mem[i] <= '0;
    end else if (cfg_ready_c) begin
      if (bus.cfg_node_we) node_mem[bus.cfg_node_addr] <= bus.cfg_node_wdata;
      if (bus.cfg_root_we) root_mem[bus.cfg_root_idx] <= bus.cfg_root_addr;
    end
  end

  // Walk state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tree_q  <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      feat_q  <= '0;
    end else begin
      state_q <= state_d;
      tree_q  <= tree_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      if (feat_ld) feat_q <= bus.in_feat;
    end
  end

  // Next-state, walk pointer and handshake decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_d     = state_q;
    tree_d      = tree_q;
    ptr_d       = ptr_q;
    depth_d     = depth_q;
    err_d       = err_q;
    feat_ld     = 1'b0;
    vote_clr    = 1'b0;
    vote_inc    = 1'b0;
    advance     = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          feat_ld  = 1'b1;
          vote_clr = 1'b1;
          err_d    = 1'b0;
          tree_d   = '0;
          ptr_d    = root_mem[0];
          depth_d  = '0;
          state_d  = WALK;
        end
      end
      WALK: begin
        if (node_leaf) begin
          advance = 1'b1;
          if (class_ok) vote_inc = 1'b1;
          else          err_d    = 1'b1;
        end else if (depth_q == DW'(MAX_DEPTH - 1)) begin
          advance = 1'b1;
          err_d   = 1'b1;
        end else begin
          ptr_d   = feat_bit ? node_t : node_f;
          depth_d = depth_q + 1'b1;
          if (bad_feat) err_d = 1'b1;
        end
        if (advance) begin
          if (last_tree) begin
            state_d = RESULT;
          end else begin
            tree_d  = tree_q + 1'b1;
            ptr_d   = root_mem[tree_q + 1'b1];
            depth_d = '0;
          end
        end
      end
      RESULT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dtree_vote_acc #(
    .N_CLASS (N_CLASS),
    .N_TREES (N_TREES)
  ) u_vote_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (vote_clr),
    .inc       (vote_inc),
    .inc_class (node_cls),
    .win_class (win_class)
  );

  // Result fields come straight from registers and hold through RESULT.
  assign bus.cfg_ready = cfg_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_class = win_class;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_dtree_walker.sv
// Self-checking bench for dtree_walker: directed scenarios plus random
// tables and vectors scored against a tree-walking reference model.
module tb_dtree_walker;
  import dtree_pkg::*;

  localparam int N_FEAT    = 51;
  localparam int N_NODES   = 64;
  localparam int N_TREES   = 4;
  localparam int N_CLASS   = 2;
  localparam int MAX_DEPTH = 16;
  localparam int FW = feat_w(N_FEAT);
  localparam int AW = addr_w(N_NODES);
  localparam int TW = clog2_min1(N_TREES);
  localparam int CW = clog2_min1(N_CLASS);
  localparam int NW = node_w(FW, AW);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dtree_walker_if #(.N_FEAT(N_FEAT), .N_NODES(N_NODES), .N_TREES(N_TREES),
                    .N_CLASS(N_CLASS)) bus ();

  dtree_walker #(.N_FEAT(N_FEAT), .N_NODES(N_NODES), .N_TREES(N_TREES),
                 .N_CLASS(N_CLASS), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference copy of the table as plain integers.
  int m_leaf [N_NODES];
  int m_feat [N_NODES];
  int m_t    [N_NODES];
  int m_f    [N_NODES];
  int m_root [N_TREES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_NODES; i++) begin
      m_leaf[i] = 1; m_feat[i] = 0; m_t[i] = 0; m_f[i] = 0;
    end
    for (int i = 0; i < N_TREES; i++) m_root[i] = 0;
  endfunction

  // Walks every tree from the rules: class, error flag and cycle cost.
  function automatic void model_eval(input logic [N_FEAT-1:0] feat, output int cls,
                                     output bit err, output int lat);
    int votes [N_CLASS];
    int best;
    for (int c = 0; c < N_CLASS; c++) votes[c] = 0;
    err = 0;
    lat = 0;
    for (int t = 0; t < N_TREES; t++) begin
      int  p     = m_root[t];
      int  steps = 0;
      bit  done  = 0;
      while (!done) begin
        lat++;
        if (m_leaf[p] != 0) begin
          int k = m_f[p] % (1 << CW);
          if (k < N_CLASS) votes[k]++;
          else             err = 1;
          done = 1;
        end else if (steps == MAX_DEPTH - 1) begin
          err  = 1;
          done = 1;
        end else begin
          bit b = 0;
          if (m_feat[p] >= N_FEAT) err = 1;
          else                     b = feat[m_feat[p]];
          p = b ? m_t[p] : m_f[p];
          steps++;
        end
      end
    end
    best = 0;
    for (int c = 1; c < N_CLASS; c++) if (votes[c] > votes[best]) best = c;
    cls = best;
  endfunction

  // One configuration cycle, driven from a falling edge; the model follows only if applied.
  task automatic cfg_write(input bit nwe, input int addr, input int leaf, input int feat,
                           input int t, input int f, input bit rwe, input int ridx,
                           input int raddr, input bit applied);
    bus.cfg_node_we    = nwe;
    bus.cfg_node_addr  = AW'(addr);
    bus.cfg_node_wdata = NW'(pack_node(leaf[0], feat, t, f, FW, AW));
    bus.cfg_root_we    = rwe;
    bus.cfg_root_idx   = TW'(ridx);
    bus.cfg_root_addr  = AW'(raddr);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_node_we = 1'b0;
    bus.cfg_root_we = 1'b0;
    if (applied) begin
      if (nwe) begin
        m_leaf[addr] = leaf; m_feat[addr] = feat; m_t[addr] = t; m_f[addr] = f;
      end
      if (rwe) m_root[ridx] = raddr;
    end
  endtask

  task automatic set_node(input int addr, input int leaf, input int feat, input int t, input int f);
    cfg_write(1'b1, addr, leaf, feat, t, f, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic set_root(input int idx, input int addr);
    cfg_write(1'b0, 0, 1, 0, 0, 0, 1'b1, idx, addr, 1'b1);
  endtask

  // Sends one vector and scores latency, class, error and the handshake.
  // hold == 0: out_ready already high; hold > 0: stall that many RESULT cycles
  // while attempting config writes that must be dropped.
  task automatic run_vector(input string tag, input logic [N_FEAT-1:0] feat, input int hold);
    int e_cls, e_lat, lat;
    bit e_err, got;
    model_eval(feat, e_cls, e_err, e_lat);
    bus.out_ready = (hold == 0);
    check({tag, ":in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_feat  = feat;
    @(posedge clk);
    lat = 0;
    got = 0;
    while (!got && lat <= 400) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) got = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check({tag, ":latency"}, got ? 64'(lat) : 64'hffff_ffff, 64'(e_lat));
    if (!got) return;
    check({tag, ":class"}, 64'(bus.out_class), 64'(e_cls));
    check({tag, ":err"}, 64'(bus.out_err), 64'(e_err));
    check({tag, ":in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      cfg_write(1'b1, 0, 1, 0, 0, 1, 1'b1, 0, 7, 1'b0);
      check({tag, ":hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ":hold_class"}, 64'(bus.out_class), 64'(e_cls));
      check({tag, ":hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, ":hold_cfg_ready"}, 64'(bus.cfg_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ":done_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, ":done_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [N_FEAT-1:0] rand_feat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N_FEAT-1:0];
  endfunction

  initial begin
    logic [N_FEAT-1:0] fv;
    bus.cfg_node_we    = 1'b0;
    bus.cfg_node_addr  = '0;
    bus.cfg_node_wdata = '0;
    bus.cfg_root_we    = 1'b0;
    bus.cfg_root_idx   = '0;
    bus.cfg_root_addr  = '0;
    bus.in_valid       = 1'b0;
    bus.in_feat        = '0;
    bus.out_ready      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst:in_ready", 64'(bus.in_ready), 64'd1);
    check("rst:cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("rst:out_valid", 64'(bus.out_valid), 64'd0);
    check("rst:out_class", 64'(bus.out_class), 64'd0);
    check("rst:out_err", 64'(bus.out_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default table evaluates to class 0 over four one-cycle trees.
    run_vector("default", rand_feat(), 0);

    // Leaf-only ensemble voting class 1.
    set_node(0, 1, 0, 0, 1);
    run_vector("leaf_only", rand_feat(), 0);

    // Tree 0 splits on feature 50; trees 1-3 are leaf 0.
    set_node(0, 1, 0, 0, 0);
    set_node(1, 0, 50, 2, 3);
    set_node(2, 1, 0, 0, 1);
    set_node(3, 1, 0, 0, 0);
    set_root(0, 1);
    fv = rand_feat(); fv[50] = 1'b1;
    run_vector("split_true", fv, 0);

    // Trees 1-2 now vote class 1.
    set_root(1, 2);
    set_root(2, 2);
    fv = rand_feat(); fv[50] = 1'b1;
    run_vector("majority1", fv, 3);

    // Votes {2,2}: tie resolves to class 0.
    fv = rand_feat(); fv[50] = 1'b0;
    run_vector("tie", fv, 0);

    // Self-looping node as root of tree 2 aborts after MAX_DEPTH cycles.
    set_node(5, 0, 0, 5, 5);
    set_root(2, 5);
    run_vector("self_loop", rand_feat(), 0);

    // Stall RESULT for 10 cycles; the config writes attempted meanwhile must be dropped.
    run_vector("stall", rand_feat(), 10);
    run_vector("after_stall", rand_feat(), 0);

    // Out-of-range feature index reads as 0 and flags an error.
    set_node(6, 0, 60, 2, 3);
    set_root(3, 6);
    run_vector("bad_feat", rand_feat(), 0);

    // Same-cycle node and root writes are both applied.
    cfg_write(1'b1, 7, 1, 0, 0, 1, 1'b1, 3, 7, 1'b1);
    run_vector("dual_write", rand_feat(), 0);

    // Random tables over a small address window and random vectors.
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 6; w++) begin
        int addr = $urandom_range(0, 15);
        int leaf = $urandom_range(0, 1);
        int feat = ($urandom_range(0, 9) == 0) ? $urandom_range(N_FEAT, (1 << FW) - 1)
                                               : $urandom_range(0, N_FEAT - 1);
        bit rwe  = $urandom_range(0, 1) == 1;
        cfg_write(1'b1, addr, leaf, feat, $urandom_range(0, 15), $urandom_range(0, 15),
                  rwe, $urandom_range(0, N_TREES - 1), $urandom_range(0, 15), 1'b1);
      end
      run_vector("random", rand_feat(), $urandom_range(0, 2));
    end

    // Reset asserted during the second WALK cycle.
    set_root(0, 5);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_feat   = rand_feat();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midrst:walking", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst:in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst:cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("midrst:out_class", 64'(bus.out_class), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_vector("post_reset", rand_feat(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
